// File: rtl/int_branch_recovery_arbiter.sv
// Picks the oldest mispredicted branch across integer lanes, holds it as a single
// recovery request, and filters or defers later mispredicts during the recovery window.
module int_branch_recovery_arbiter #(
    parameter int ISSUE_WIDTH = 2,
    parameter int ALPTR_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic [ISSUE_WIDTH-1:0]            lane_valid,
    input  logic [ISSUE_WIDTH-1:0]            lane_mispred,
    input  logic [ISSUE_WIDTH*ALPTR_WIDTH-1:0] lane_alptr,
    input  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]  lane_target,
    input  logic [ALPTR_WIDTH-1:0]            head_ptr,
    output logic                              req_valid,
    input  logic                              req_ready,
    output logic [ALPTR_WIDTH-1:0]            req_alptr,
    output logic [ADDR_WIDTH-1:0]             req_target,
    input  logic                              recovery_done,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              mispred_count,
    output logic [CNT_WIDTH-1:0]              suppressed_count
);

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_WAIT_DONE} state_t;

    state_t                  r_state;
    logic [ALPTR_WIDTH-1:0]  r_held_ptr;
    logic [ADDR_WIDTH-1:0]   r_held_tgt;
    logic [ALPTR_WIDTH-1:0]  r_sent_ptr;
    logic                    r_def_valid;
    logic [ALPTR_WIDTH-1:0]  r_def_ptr;
    logic [ADDR_WIDTH-1:0]   r_def_tgt;
    logic [CNT_WIDTH-1:0]    r_mispred_cnt;
    logic [CNT_WIDTH-1:0]    r_supp_cnt;

    logic                    w_cand_valid;
    logic [ALPTR_WIDTH-1:0]  w_cand_ptr;
    logic [ADDR_WIDTH-1:0]   w_cand_tgt;
    logic [ALPTR_WIDTH-1:0]  w_cand_age;
    logic                    w_older_held;
    logic                    w_older_sent;
    logic                    w_older_def;
    logic                    w_def_nv;
    logic [ALPTR_WIDTH-1:0]  w_def_nptr;
    logic [ADDR_WIDTH-1:0]   w_def_ntgt;
    logic                    w_mc_inc;
    logic                    w_sc_inc;

    // Modular distance from the active-list head; unsigned subtraction wraps naturally.
    function automatic logic [ALPTR_WIDTH-1:0] f_age(input logic [ALPTR_WIDTH-1:0] p,
                                                     input logic [ALPTR_WIDTH-1:0] h);
        return p - h;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_ptr   = '0;
        w_cand_tgt   = '0;
        w_cand_age   = '1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (lane_valid[i] && lane_mispred[i] && !stall) begin
                // Strict less-than keeps the lower lane on an age tie.
                if (!w_cand_valid ||
                    f_age(lane_alptr[i*ALPTR_WIDTH +: ALPTR_WIDTH], head_ptr) < w_cand_age) begin
                    w_cand_valid = 1'b1;
                    w_cand_ptr   = lane_alptr[i*ALPTR_WIDTH +: ALPTR_WIDTH];
                    w_cand_tgt   = lane_target[i*ADDR_WIDTH +: ADDR_WIDTH];
                    w_cand_age   = f_age(lane_alptr[i*ALPTR_WIDTH +: ALPTR_WIDTH], head_ptr);
                end
            end
        end
    end

    assign w_older_held = w_cand_age < f_age(r_held_ptr, head_ptr);
    assign w_older_sent = w_cand_age < f_age(r_sent_ptr, head_ptr);
    assign w_older_def  = w_cand_age < f_age(r_def_ptr,  head_ptr);

    always_comb begin
        w_def_nv   = r_def_valid;
        w_def_nptr = r_def_ptr;
        w_def_ntgt = r_def_tgt;
        if (w_cand_valid && w_older_sent && (!r_def_valid || w_older_def)) begin
            w_def_nv   = 1'b1;
            w_def_nptr = w_cand_ptr;
            w_def_ntgt = w_cand_tgt;
        end
    end

    assign w_mc_inc = (r_state == S_PENDING) && req_ready;
    assign w_sc_inc = w_cand_valid &&
                      (((r_state == S_PENDING) && !(req_ready && w_older_held)) ||
                       ((r_state == S_WAIT_DONE) && !w_older_sent));

    // NOTE: sequential state uses non-blocking assignments only; held registers are
    // reset because req_alptr/req_target must read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_held_ptr  <= '0;
            r_held_tgt  <= '0;
            r_sent_ptr  <= '0;
            r_def_valid <= 1'b0;
            r_def_ptr   <= '0;
            r_def_tgt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand_valid) begin
                        r_held_ptr <= w_cand_ptr;
                        r_held_tgt <= w_cand_tgt;
                        r_state    <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (req_ready) begin
                        r_sent_ptr <= r_held_ptr;
                        r_state    <= S_WAIT_DONE;
                        if (w_cand_valid && w_older_held) begin
                            r_def_valid <= 1'b1;
                            r_def_ptr   <= w_cand_ptr;
                            r_def_tgt   <= w_cand_tgt;
                        end
                    end else if (w_cand_valid && w_older_held) begin
                        r_held_ptr <= w_cand_ptr;
                        r_held_tgt <= w_cand_tgt;
                    end
                end
                S_WAIT_DONE: begin
                    r_def_valid <= w_def_nv;
                    r_def_ptr   <= w_def_nptr;
                    r_def_tgt   <= w_def_ntgt;
                    if (recovery_done) begin
                        r_def_valid <= 1'b0;
                        if (w_def_nv) begin
                            r_held_ptr <= w_def_nptr;
                            r_held_tgt <= w_def_ntgt;
                            r_state    <= S_PENDING;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mispred_cnt <= '0;
            r_supp_cnt    <= '0;
        end else begin
            if (w_mc_inc && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
            if (w_sc_inc && (r_supp_cnt != '1))    r_supp_cnt    <= r_supp_cnt + 1'b1;
        end
    end

    assign req_valid        = (r_state == S_PENDING);
    assign busy             = (r_state != S_IDLE);
    assign req_alptr        = r_held_ptr;
    assign req_target       = r_held_tgt;
    assign mispred_count    = r_mispred_cnt;
    assign suppressed_count = r_supp_cnt;

endmodule

// File: tb/tb_int_branch_recovery_arbiter.sv
// Directed vector table for the branch recovery arbiter, plus a narrow-counter
// instance for saturation and hand sequences for asynchronous reset.
module tb_int_branch_recovery_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  lane_valid, lane_mispred;
    logic [11:0] lane_alptr;
    logic [63:0] lane_target;
    logic [5:0]  head_ptr;
    logic        req_ready, recovery_done;
    logic        req_valid, busy;
    logic [5:0]  req_alptr;
    logic [31:0] req_target;
    logic [15:0] mispred_count, suppressed_count;
    logic        s_req_valid, s_busy;
    logic [5:0]  s_req_alptr;
    logic [31:0] s_req_target;
    logic [1:0]  s_mispred_count, s_suppressed_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_branch_recovery_arbiter dut (
        .clk(clk), .rst(rst), .stall(stall),
        .lane_valid(lane_valid), .lane_mispred(lane_mispred),
        .lane_alptr(lane_alptr), .lane_target(lane_target), .head_ptr(head_ptr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alptr(req_alptr), .req_target(req_target),
        .recovery_done(recovery_done), .busy(busy),
        .mispred_count(mispred_count), .suppressed_count(suppressed_count)
    );

    int_branch_recovery_arbiter #(.CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .stall(stall),
        .lane_valid(lane_valid), .lane_mispred(lane_mispred),
        .lane_alptr(lane_alptr), .lane_target(lane_target), .head_ptr(head_ptr),
        .req_valid(s_req_valid), .req_ready(req_ready),
        .req_alptr(s_req_alptr), .req_target(s_req_target),
        .recovery_done(recovery_done), .busy(s_busy),
        .mispred_count(s_mispred_count), .suppressed_count(s_suppressed_count)
    );

    typedef struct packed {
        logic        st;
        logic [1:0]  lv;
        logic [1:0]  lm;
        logic [5:0]  a0;
        logic [31:0] t0;
        logic [5:0]  a1;
        logic [31:0] t1;
        logic [5:0]  hd;
        logic        rdy;
        logic        dn;
        logic        rv;
        logic [5:0]  ra;
        logic [31:0] rt;
        logic        bz;
        logic [15:0] mc;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [1:0] lv, input logic [1:0] lm,
                       input logic [5:0] a0, input logic [31:0] t0,
                       input logic [5:0] a1, input logic [31:0] t1,
                       input logic [5:0] hd, input logic rdy, input logic dn,
                       input logic rv, input logic [5:0] ra, input logic [31:0] rt,
                       input logic bz, input logic [15:0] mc, input logic [15:0] sc);
        vec_t v;
        v.st = st; v.lv = lv; v.lm = lm; v.a0 = a0; v.t0 = t0; v.a1 = a1; v.t1 = t1;
        v.hd = hd; v.rdy = rdy; v.dn = dn;
        v.rv = rv; v.ra = ra; v.rt = rt; v.bz = bz; v.mc = mc; v.sc = sc;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] sat3(input logic [15:0] x);
        return (x > 16'd3) ? 32'd3 : {16'd0, x};
    endfunction

    task automatic idle_inputs();
        stall = 0; lane_valid = 0; lane_mispred = 0; lane_alptr = 0; lane_target = 0;
        head_ptr = 0; req_ready = 0; recovery_done = 0;
    endtask

    initial begin
        vec_t v;
        logic prev_rv;
        logic [15:0] prev_mc;

        //  st lv lm  a0  t0       a1  t1       hd  rdy dn | rv ra  rt       bz mc sc
        add(0, 1, 1,  5, 'h100,    0,  0,       0,  0, 0,   1,  5, 'h100,   1, 0, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 0,   1,  5, 'h100,   1, 0, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 0,   1,  5, 'h100,   1, 0, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 0,   1,  5, 'h100,   1, 0, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  5, 'h100,   1, 1, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   0,  5, 'h100,   0, 1, 0);
        add(0, 3, 3,  9, 'h900,    4, 'h400,    0,  0, 0,   1,  4, 'h400,   1, 1, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  4, 'h400,   1, 2, 0);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   0,  4, 'h400,   0, 2, 0);
        add(0, 1, 1, 10, 'hA00,    0,  0,       0,  0, 0,   1, 10, 'hA00,   1, 2, 0);
        add(0, 2, 2,  0, 0,        3, 'h300,    0,  0, 0,   1,  3, 'h300,   1, 2, 1);
        add(0, 1, 1, 20, 'h1400,   0,  0,       0,  0, 0,   1,  3, 'h300,   1, 2, 2);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  3, 'h300,   1, 3, 2);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   0,  3, 'h300,   0, 3, 2);
        add(0, 3, 3,  2, 'h222,   62, 'h626,   60,  0, 0,   1, 62, 'h626,   1, 3, 2);
        add(0, 1, 1, 63, 'h633,    0,  0,      60,  0, 0,   1, 62, 'h626,   1, 3, 3);
        add(0, 2, 2,  0, 0,       61, 'h611,   60,  0, 0,   1, 61, 'h611,   1, 3, 4);
        add(0, 0, 0,  0, 0,        0,  0,      60,  1, 0,   0, 61, 'h611,   1, 4, 4);
        add(0, 0, 0,  0, 0,        0,  0,      60,  0, 1,   0, 61, 'h611,   0, 4, 4);
        add(0, 1, 1,  8, 'h800,    0,  0,       0,  0, 0,   1,  8, 'h800,   1, 4, 4);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  8, 'h800,   1, 5, 4);
        add(0, 1, 1, 12, 'hC00,    0,  0,       0,  0, 0,   0,  8, 'h800,   1, 5, 5);
        add(0, 2, 2,  0, 0,        6, 'h600,    0,  0, 0,   0,  8, 'h800,   1, 5, 5);
        add(0, 1, 1,  7, 'h700,    0,  0,       0,  0, 0,   0,  8, 'h800,   1, 5, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   1,  6, 'h600,   1, 5, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  6, 'h600,   1, 6, 5);
        add(0, 1, 1,  3, 'h300,    0,  0,       0,  0, 1,   1,  3, 'h300,   1, 6, 5);
        add(0, 2, 2,  0, 0,        1, 'h111,    0,  1, 0,   0,  3, 'h300,   1, 7, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   1,  1, 'h111,   1, 7, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 0,   0,  1, 'h111,   1, 8, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  0, 1,   0,  1, 'h111,   0, 8, 5);
        add(0, 0, 0,  0, 0,        0,  0,       0,  1, 1,   0,  1, 'h111,   0, 8, 5);
        add(0, 3, 3,  7, 'h777,    7, 'h070,    0,  0, 0,   1,  7, 'h777,   1, 8, 5);
        add(1, 1, 1,  2, 'h202,    0,  0,       0,  0, 0,   1,  7, 'h777,   1, 8, 5);
        add(1, 2, 2,  0, 0,       30, 'h1E00,   0,  0, 0,   1,  7, 'h777,   1, 8, 5);
        add(0, 1, 0,  1, 'h101,    0,  0,       0,  0, 0,   1,  7, 'h777,   1, 8, 5);

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_valid", {31'd0, req_valid}, 32'd0);
        check("reset req_alptr", {26'd0, req_alptr}, 32'd0);
        check("reset req_target", req_target, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset mispred_count", {16'd0, mispred_count}, 32'd0);
        check("reset suppressed_count", {16'd0, suppressed_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        prev_rv = 1'b0;
        prev_mc = 16'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            stall = v.st; lane_valid = v.lv; lane_mispred = v.lm;
            lane_alptr = {v.a1, v.a0}; lane_target = {v.t1, v.t0};
            head_ptr = v.hd; req_ready = v.rdy; recovery_done = v.dn;
            #1;
            check($sformatf("v%0d pre-edge req_valid", i), {31'd0, req_valid}, {31'd0, prev_rv});
            check($sformatf("v%0d pre-edge mispred_count", i), {16'd0, mispred_count}, {16'd0, prev_mc});
            @(posedge clk);
            #1;
            check($sformatf("v%0d req_valid", i), {31'd0, req_valid}, {31'd0, v.rv});
            check($sformatf("v%0d req_alptr", i), {26'd0, req_alptr}, {26'd0, v.ra});
            check($sformatf("v%0d req_target", i), req_target, v.rt);
            check($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, v.bz});
            check($sformatf("v%0d mispred_count", i), {16'd0, mispred_count}, {16'd0, v.mc});
            check($sformatf("v%0d suppressed_count", i), {16'd0, suppressed_count}, {16'd0, v.sc});
            check($sformatf("v%0d sat mispred_count", i), {30'd0, s_mispred_count}, sat3(v.mc));
            check($sformatf("v%0d sat suppressed_count", i), {30'd0, s_suppressed_count}, sat3(v.sc));
            prev_rv = v.rv;
            prev_mc = v.mc;
        end

        // Asynchronous reset in the middle of a low clock phase while PENDING.
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("async rst req_valid", {31'd0, req_valid}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst req_alptr", {26'd0, req_alptr}, 32'd0);
        check("async rst req_target", req_target, 32'd0);
        check("async rst mispred_count", {16'd0, mispred_count}, 32'd0);
        check("async rst suppressed_count", {16'd0, suppressed_count}, 32'd0);
        check("async rst sat mispred_count", {30'd0, s_mispred_count}, 32'd0);
        @(posedge clk);
        #1;
        check("held rst req_valid", {31'd0, req_valid}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        lane_valid = 2'b01; lane_mispred = 2'b01;
        lane_alptr = {6'd0, 6'd5}; lane_target = {32'd0, 32'h55};
        #1;
        check("post rst no comb req", {31'd0, req_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post rst req_valid", {31'd0, req_valid}, 32'd1);
        check("post rst req_alptr", {26'd0, req_alptr}, 32'd5);
        check("post rst req_target", req_target, 32'h55);
        check("post rst mispred_count", {16'd0, mispred_count}, 32'd0);
        @(negedge clk);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_branch_recovery_arbiter.md
Name: int_branch_recovery_arbiter

Overview:
- Sits between the integer execution lanes and the recovery manager.
- Each cycle it collects per-lane branch results and selects the oldest mispredicted branch by active-list age.
- It holds that branch as a single recovery request until the recovery manager accepts it.
- It then tracks the recovery window so that mispredicts from younger ops are suppressed and older ones are queued.

Parameters:
ISSUE_WIDTH, 2, number of integer execution lanes
ALPTR_WIDTH, 6, active-list pointer width (includes no wrap bit; age is modular)
ADDR_WIDTH, 32, PC/target address width
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stall  in  1  backend stall; lane inputs ignored when 1
lane_valid  in  ISSUE_WIDTH  branch result valid per lane (brResult.valid)
lane_mispred  in  ISSUE_WIDTH  misprediction per lane
lane_alptr  in  ISSUE_WIDTH*ALPTR_WIDTH  active-list pointer per lane, lane i at [i*ALPTR_WIDTH +: ALPTR_WIDTH]
lane_target  in  ISSUE_WIDTH*ADDR_WIDTH  resolved next PC per lane
head_ptr  in  ALPTR_WIDTH  active-list head (oldest in-flight op)
req_valid  out  1  recovery request pending
req_ready  in  1  recovery manager accepts request
req_alptr  out  ALPTR_WIDTH  active-list pointer of the mispredicted branch
req_target  out  ADDR_WIDTH  correct fetch address
recovery_done  in  1  one-cycle pulse: recovery for the accepted request complete
busy  out  1  state != IDLE
mispred_count  out  CNT_WIDTH  saturating count of accepted requests
suppressed_count  out  CNT_WIDTH  saturating count of candidates discarded as younger

Behaviour:
Reset:
- rst=0 forces state=IDLE, req_valid=0, req_alptr=0, req_target=0, busy=0, both counters=0.
- Takes effect immediately, including mid-request; any held request is lost.

Age:
- age(p) = (p - head_ptr) mod 2^ALPTR_WIDTH; a smaller age is older.
- "Older than held" means age(cand) < age(held), both evaluated with the current head_ptr.

Candidate selection (combinational, same cycle):
- A lane is eligible when lane_valid & lane_mispred & !stall.
- The winner is the eligible lane with the minimum age; on equal age the lower lane index wins.
- No eligible lane means no candidate.

State machine:
- IDLE
  - Candidate: latch its alptr/target into the held registers next edge and go to PENDING.
- PENDING
  - req_valid=1; req_alptr/req_target driven from the held registers and stable while unaccepted.
  - req_valid & req_ready: handshake fires; mispred_count increments; go to WAIT_DONE with sent_ptr = held alptr.
  - Candidate in the same cycle as the handshake and older than held: latch it, set the deferred flag, go to WAIT_DONE.
  - No handshake, candidate older than held: replace the held registers; the younger held request is dropped and suppressed_count increments.
  - No handshake, candidate not older than held: candidate discarded; suppressed_count increments.
- WAIT_DONE
  - req_valid=0.
  - Candidate older than sent_ptr, no deferred entry: latch it and set deferred.
  - Candidate older than sent_ptr, deferred entry present: keep the older of the two.
  - Candidate not older than sent_ptr (being flushed): discarded; suppressed_count increments.
  - recovery_done: go to PENDING if deferred is set (deferred becomes held), otherwise IDLE.
  - A candidate arriving in the same cycle as recovery_done is still evaluated against sent_ptr, then merged into the deferred entry.

Other rules:
- Latency: first mispredict seen at edge N gives req_valid=1 in cycle N+1. Requests never issue combinationally.
- Counters saturate at all-ones and never wrap.
- recovery_done outside WAIT_DONE is ignored. req_ready outside PENDING is ignored.
- Ptr wrap: ages are computed modulo, so head_ptr=60, alptr=2 gives age 6 (ALPTR_WIDTH=6), older than alptr=63 (age 3)? No: 3<6, so 63 is older. Ordering must follow the modular age only.

Test Plan:
1. Reset, then lane0 mispred alptr=5, target=0x100, head=0, req_ready=0. Expect req_valid=1 next cycle with alptr=5, target=0x100. Hold 3 cycles with outputs stable. Raise req_ready; then mispred_count=1 and state WAIT_DONE.
2. Same cycle: lane0 alptr=9 and lane1 alptr=4, both mispredicted, head=0. Expect the request to carry alptr=4 and lane1's target.
3. PENDING with held alptr=10, head=0, no ready. New mispred alptr=3 replaces held and suppressed_count=1. Next mispred alptr=20 is discarded and suppressed_count=2. Request shows alptr=3.
4. Wrap: head=60, lane0 alptr=2, lane1 alptr=62. Expect alptr=62 selected (age 2 vs 6).
5. WAIT_DONE with sent_ptr=8: a mispred at alptr=12 is suppressed; a mispred at alptr=6 is deferred. On recovery_done, req_valid=1 with alptr=6 the next cycle and mispred_count increments on its accept.
6. stall=1 with valid mispred inputs: no state change. Assert rst=0 while PENDING: req_valid drops to 0 asynchronously and the counters clear.
